clock_set_ctrl: RTL and testbench

Time-keeping and time-setting controller for the six-digit HH:MM:SS clock display. It holds the current time as packed BCD and advances it on an external 1 Hz tick. It runs a mode state machine driven by two debounced buttons that lets the user select and increment hours, minutes or seconds. Its outputs feed the display multiplexer directly: `hh`/`mm`/`ss`, the blink gate `blink_en` and the field select `blink_sel`.

---
 rtl/clock_pkg.sv | 30 +++
 rtl/bcd2_counter.sv | 39 +++
 rtl/clock_set_ctrl.sv | 160 ++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the HH:MM:SS time-keeping / time-setting controller.
package clock_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_SET_HH = 2'd1,
      ST_SET_MM = 2'd2,
      ST_SET_SS = 2'd3
   } clk_state_t;

   localparam logic [1:0] SEL_HH   = 2'b00;
   localparam logic [1:0] SEL_MM   = 2'b01;
   localparam logic [1:0] SEL_SS   = 2'b10;
   localparam logic [1:0] SEL_NONE = 2'b11;

   localparam logic [7:0] HH_MAX = 8'h23;
   localparam logic [7:0] MS_MAX = 8'h59;

   // Plain two-digit BCD increment; the limit wrap is applied by the caller.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] == 4'h9) begin
         r = {v[7:4] + 4'h1, 4'h0};
      end else begin
         r = {v[7:4], v[3:0] + 4'h1};
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter; wrap flags the increment that passes MAX and is fed back to load.
module bcd2_counter
   import clock_pkg::*;
#(
   parameter logic [7:0] MAX  = MS_MAX,
   parameter logic [7:0] INIT = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inc,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [7:0] value,
   output logic       wrap
);

   logic [7:0] value_q, value_d;

   assign wrap  = inc & (value_q == MAX);
   assign value = value_q;

   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = load_val;
      end else if (inc) begin
         value_d = bcd_inc(value_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= INIT;
      end else begin
         value_q <= value_d;
      end
   end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-keeping and setting controller: BCD HH:MM:SS with RUN / SET_xx mode FSM.
// Optional hold-to-repeat on btn_inc is built when CLOCK_SET_AUTOREPEAT_EN is defined.
//
// state     | meaning
// ST_RUN    | time advances on tick_1hz, no field selected
// ST_SET_HH | time frozen, btn_inc bumps hours, hours blink
// ST_SET_MM | time frozen, btn_inc bumps minutes, minutes blink
// ST_SET_SS | time frozen, btn_inc bumps seconds, seconds blink
module clock_set_ctrl
   import clock_pkg::*;
#(
   parameter logic [7:0] INIT_HH    = 8'h12,
   parameter logic [7:0] INIT_MM    = 8'h00,
   parameter logic [7:0] INIT_SS    = 8'h00,
   parameter int         HOLD_TICKS = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_1hz,
   input  logic       tick_2hz,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic [7:0] hh,
   output logic [7:0] mm,
   output logic [7:0] ss,
   output logic       blink_en,
   output logic [1:0] blink_sel
);

   clk_state_t state_q, state_d;
   logic       mode_prev_q, inc_prev_q;
   logic       blink_en_q, blink_en_d;
   logic [1:0] blink_sel_q, blink_sel_d;

   logic mode_press, inc_press, in_set, repeat_inc, field_inc;
   logic hh_inc, mm_inc, ss_inc;
   logic hh_wrap, mm_wrap, ss_wrap;

   assign mode_press = btn_mode & ~mode_prev_q;
   assign inc_press  = btn_inc & ~inc_prev_q;
   assign in_set     = (state_q != ST_RUN);

`ifdef CLOCK_SET_AUTOREPEAT_EN
   localparam logic [7:0] HOLD_LIM = 8'(HOLD_TICKS);

   logic [7:0] hold_cnt_q, hold_cnt_d;

   always_comb begin
      hold_cnt_d = hold_cnt_q;
      repeat_inc = 1'b0;
      if (!in_set || !btn_inc || mode_press) begin
         hold_cnt_d = '0;
      end else if (tick_2hz) begin
         if (hold_cnt_q >= HOLD_LIM) begin
            repeat_inc = 1'b1;
         end else begin
            hold_cnt_d = hold_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt_q <= '0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
      end
   end
`else
   assign repeat_inc = 1'b0;
`endif

   // A mode press on the same edge swallows any pending increment.
   assign field_inc = in_set & ~mode_press & (inc_press | repeat_inc);

   assign ss_inc = in_set ? (field_inc & (state_q == ST_SET_SS)) : tick_1hz;
   assign mm_inc = in_set ? (field_inc & (state_q == ST_SET_MM)) : ss_wrap;
   assign hh_inc = in_set ? (field_inc & (state_q == ST_SET_HH)) : mm_wrap;

   always_comb begin
      state_d = state_q;
      if (mode_press) begin
         case (state_q)
            ST_RUN:    state_d = ST_SET_HH;
            ST_SET_HH: state_d = ST_SET_MM;
            ST_SET_MM: state_d = ST_SET_SS;
            default:   state_d = ST_RUN;
         endcase
      end
   end

   always_comb begin
      blink_sel_d = SEL_NONE;
      case (state_d)
         ST_SET_HH: blink_sel_d = SEL_HH;
         ST_SET_MM: blink_sel_d = SEL_MM;
         ST_SET_SS: blink_sel_d = SEL_SS;
         default:   blink_sel_d = SEL_NONE;
      endcase
   end

   always_comb begin
      blink_en_d = blink_en_q;
      if ((state_d == ST_RUN) || (state_d != state_q) || field_inc) begin
         blink_en_d = 1'b0;
      end else if (tick_2hz) begin
         blink_en_d = ~blink_en_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         mode_prev_q <= 1'b1;
         inc_prev_q  <= 1'b1;
         blink_en_q  <= 1'b0;
         blink_sel_q <= SEL_NONE;
      end else begin
         state_q     <= state_d;
         mode_prev_q <= btn_mode;
         inc_prev_q  <= btn_inc;
         blink_en_q  <= blink_en_d;
         blink_sel_q <= blink_sel_d;
      end
   end

   bcd2_counter #(.MAX(MS_MAX), .INIT(INIT_SS)) u_ss (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (ss_inc),
      .load     (ss_wrap),
      .load_val (8'h00),
      .value    (ss),
      .wrap     (ss_wrap)
   );

   bcd2_counter #(.MAX(MS_MAX), .INIT(INIT_MM)) u_mm (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (mm_inc),
      .load     (mm_wrap),
      .load_val (8'h00),
      .value    (mm),
      .wrap     (mm_wrap)
   );

   bcd2_counter #(.MAX(HH_MAX), .INIT(INIT_HH)) u_hh (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (hh_inc),
      .load     (hh_wrap),
      .load_val (8'h00),
      .value    (hh),
      .wrap     (hh_wrap)
   );

   assign blink_en  = blink_en_q;
   assign blink_sel = blink_sel_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed steps plus random traffic against a seconds-based model.
module tb_clock_set_ctrl;

   localparam int HOLD = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       tick_1hz = 1'b0, tick_2hz = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
   logic [7:0] hh, mm, ss;
   logic       blink_en;
   logic [1:0] blink_sel;

   logic       tick_w = 1'b0;
   logic [7:0] w_hh, w_mm, w_ss;
   logic       w_blink_en;
   logic [1:0] w_blink_sel;

   int n_assert = 0;
   int n_fail   = 0;

   // model: time as integers, mode 0=RUN 1=HH 2=MM 3=SS
   int m_h, m_m, m_s, m_mode, m_hold;
   bit m_blink, m_pm, m_pi;

   always #5 clk = ~clk;

   clock_set_ctrl #(.HOLD_TICKS(HOLD)) u_dut (
      .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
      .btn_mode(btn_mode), .btn_inc(btn_inc),
      .hh(hh), .mm(mm), .ss(ss), .blink_en(blink_en), .blink_sel(blink_sel)
   );

   clock_set_ctrl #(.INIT_HH(8'h23), .INIT_MM(8'h59), .INIT_SS(8'h58), .HOLD_TICKS(HOLD)) u_wrap (
      .clk(clk), .rst_n(rst_n), .tick_1hz(tick_w), .tick_2hz(1'b0),
      .btn_mode(1'b0), .btn_inc(1'b0),
      .hh(w_hh), .mm(w_mm), .ss(w_ss), .blink_en(w_blink_en), .blink_sel(w_blink_sel)
   );

   function automatic logic [7:0] to_bcd(input int n);
      return {4'(n / 10), 4'(n % 10)};
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_h = 12; m_m = 0; m_s = 0; m_mode = 0; m_hold = 0;
      m_blink = 1'b0; m_pm = 1'b1; m_pi = 1'b1;
   endtask

   task automatic model_step(input bit bm, input bit bi, input bit t1, input bit t2);
      bit mp, ip, rep, do_inc;
      int tot;
      mp = bm && !m_pm;
      ip = bi && !m_pi;
      rep = 1'b0;
      if (m_mode == 0) begin
         if (t1) begin
            tot = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
            m_h = tot / 3600;
            m_m = (tot / 60) % 60;
            m_s = tot % 60;
         end
         m_blink = 1'b0;
         m_hold = 0;
      end else begin
`ifdef CLOCK_SET_AUTOREPEAT_EN
         if (bi && !mp) begin
            if (t2) begin
               if (m_hold >= HOLD) rep = 1'b1;
               else m_hold++;
            end
         end else begin
            m_hold = 0;
         end
`endif
         do_inc = (ip || rep) && !mp;
         if (do_inc) begin
            case (m_mode)
               1: m_h = (m_h + 1) % 24;
               2: m_m = (m_m + 1) % 60;
               default: m_s = (m_s + 1) % 60;
            endcase
            m_blink = 1'b0;
         end else if (t2) begin
            m_blink = !m_blink;
         end
      end
      if (mp) begin
         m_mode = (m_mode + 1) % 4;
         m_blink = 1'b0;
         m_hold = 0;
      end
      m_pm = bm;
      m_pi = bi;
   endtask

   task automatic check_all(input string tag);
      logic [7:0] exp_sel;
      exp_sel = (m_mode == 0) ? 8'd3 : 8'(m_mode - 1);
      chk({tag, ".hh"}, hh, to_bcd(m_h));
      chk({tag, ".mm"}, mm, to_bcd(m_m));
      chk({tag, ".ss"}, ss, to_bcd(m_s));
      chk({tag, ".blink_en"}, {7'd0, blink_en}, {7'd0, m_blink});
      chk({tag, ".blink_sel"}, {6'd0, blink_sel}, exp_sel);
   endtask

   task automatic step(input string tag, input bit bm, input bit bi, input bit t1, input bit t2);
      btn_mode = bm; btn_inc = bi; tick_1hz = t1; tick_2hz = t2;
      model_step(bm, bi, t1, t2);
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic press_inc(input string tag);
      step(tag, 1'b0, 1'b1, 1'b0, 1'b0);
      step(tag, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic press_mode(input string tag);
      step(tag, 1'b1, 1'b0, 1'b0, 1'b0);
      step(tag, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic async_reset(input string tag);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all(tag);
      chk({tag, ".init_hh"}, hh, 8'h12);
      chk({tag, ".init_sel"}, {6'd0, blink_sel}, 8'h03);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int n;
      model_reset();
      #2 rst_n = 1'b0;
      btn_mode = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst_n = 1'b1;

      // mode held through reset release must not count as a press
      step("held_mode", 1'b1, 1'b0, 1'b0, 1'b0);
      chk("held_mode.sel", {6'd0, blink_sel}, 8'h03);
      step("idle", 1'b0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 3; i++) begin
         step("run_tick", 1'b0, 1'b0, 1'b1, 1'b0);
         step("run_idle", 1'b0, 1'b0, 1'b0, 1'b0);
      end
      chk("run3.hh", hh, 8'h12);
      chk("run3.ss", ss, 8'h03);
      chk("run3.blink", {7'd0, blink_en}, 8'h00);

      tick_w = 1'b1;
      step("wrap_t1", 1'b0, 1'b0, 1'b0, 1'b0);
      tick_w = 1'b0;
      chk("wrap1", {w_hh, w_mm, w_ss} == 24'h235959 ? 8'h01 : 8'h00, 8'h01);
      tick_w = 1'b1;
      step("wrap_t2", 1'b0, 1'b0, 1'b0, 1'b0);
      tick_w = 1'b0;
      chk("wrap2.hh", w_hh, 8'h00);
      chk("wrap2.mm", w_mm, 8'h00);
      chk("wrap2.ss", w_ss, 8'h00);
      chk("wrap2.sel", {6'd0, w_blink_sel}, 8'h03);

      press_mode("to_hh");
      chk("set_hh.sel", {6'd0, blink_sel}, 8'h00);
      step("hh_tick_ignored", 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 12; i++) press_inc("hh_inc");
      chk("hh12.hh", hh, 8'h00);
      chk("hh12.mm", mm, 8'h00);
      chk("hh12.ss", ss, 8'h03);

      press_mode("to_mm");
      for (int i = 0; i < 59; i++) press_inc("mm_inc");
      chk("mm59", mm, 8'h59);
      press_inc("mm_wrap");
      chk("mm_wrap.mm", mm, 8'h00);
      chk("mm_wrap.hh", hh, 8'h00);
      step("mode_and_inc", 1'b1, 1'b1, 1'b0, 1'b0);
      chk("mode_and_inc.sel", {6'd0, blink_sel}, 8'h02);
      chk("mode_and_inc.mm", mm, 8'h00);
      step("idle", 1'b0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 4; i++) begin
         step("blink", 1'b0, 1'b0, 1'b0, 1'b1);
         chk("blink.seq", {7'd0, blink_en}, (i % 2 == 0) ? 8'h01 : 8'h00);
         step("blink_idle", 1'b0, 1'b0, 1'b0, 1'b0);
      end
      step("blink_on", 1'b0, 1'b0, 1'b0, 1'b1);
      step("inc_clears", 1'b0, 1'b1, 1'b0, 1'b0);
      chk("inc_clears.blink", {7'd0, blink_en}, 8'h00);
      step("idle", 1'b0, 1'b0, 1'b0, 1'b0);
      step("blink_on2", 1'b0, 1'b0, 1'b0, 1'b1);
      step("inc_and_t2", 1'b0, 1'b1, 1'b0, 1'b1);
      chk("inc_and_t2.blink", {7'd0, blink_en}, 8'h00);
      step("idle", 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef CLOCK_SET_AUTOREPEAT_EN
      n = (60 - m_s) % 60;
      for (int i = 0; i < n; i++) press_inc("to_ss00");
      chk("ss00", ss, 8'h00);
      step("hold_press", 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step("hold_t2", 1'b0, 1'b1, 1'b0, 1'b1);
         step("hold", 1'b0, 1'b1, 1'b0, 1'b0);
      end
      chk("autorepeat.ss", ss, 8'h04);
      async_reset("reset_mid_hold");
      step("after_hold_rst", 1'b0, 1'b1, 1'b0, 1'b0);
      step("idle", 1'b0, 1'b0, 1'b0, 1'b0);
`else
      async_reset("reset_mid_set");
`endif

      for (int i = 0; i < 800; i++) begin
         n = 0;
         step("rand", ($urandom % 12) == 0, ($urandom % 3) == 0,
              ($urandom % 4) == 0, ($urandom % 4) == 0);
      end

      async_reset("reset_end");
      step("post_reset", 1'b0, 1'b0, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
